// File: rtl/led_pkg.sv
// Shared constants and types for the LED fade stage that sits behind the 8-bit chaser.
package led_pkg;

    localparam int LED_W        = 8;
    localparam int PWM_BITS_DEF = 4;

    typedef logic [PWM_BITS_DEF-1:0] level_t;

    // Brightest level for a given PWM resolution; also the PWM period in cycles.
    function automatic int maxl(input int bits);
        return (1 << bits) - 1;
    endfunction

endpackage

// File: rtl/led_fade_pwm_if.sv
// Pattern-in / LED-drive bundle between the chaser (master) and the fade stage (slave).
interface led_fade_pwm_if;
    import led_pkg::*;

    logic [LED_W-1:0] pat_in;
    logic [LED_W-1:0] led_out;
    logic             busy;

    modport master (
        output pat_in,
        input  led_out,
        input  busy
    );

    modport slave (
        input  pat_in,
        output led_out,
        output busy
    );

endinterface

// File: rtl/fade_channel.sv
// One LED channel: a lit request loads full brightness, then each tick dims it by one step.
module fade_channel
    import led_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                CLK,
    input  logic                rs,
    input  logic                pat_bit,
    input  logic                tick,
    input  logic [PWM_BITS-1:0] pwm_cnt,
    output logic                led_bit,
    output logic                active
);

    localparam logic [PWM_BITS-1:0] MAXL = PWM_BITS'(maxl(PWM_BITS));

    logic [PWM_BITS-1:0] level;

    // A request always wins over a coincident tick, so a re-trigger never dips.
    always_ff @(posedge CLK) begin
        if (rs) begin
            level   <= '0;
            led_bit <= 1'b0;
        end else begin
            if (pat_bit) begin
                level <= MAXL;
            end else if (tick && (level != '0)) begin
                level <= level - PWM_BITS'(1);
            end
            led_bit <= (pwm_cnt < level);
        end
    end

    assign active = (level != '0);

endmodule

// File: rtl/led_fade_pwm.sv
// Fade stage top: shared step prescaler and PWM counter feeding eight fade channels.
module led_fade_pwm
    import led_pkg::*;
#(
    parameter int PWM_BITS = 4,
    parameter int STEP_DIV = 3_125_000
) (
    input  logic           CLK,
    input  logic           rs,
    led_fade_pwm_if.slave  bus
);

    localparam int                  DIV_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] PWM_LAST = PWM_BITS'(maxl(PWM_BITS) - 1);

    logic [DIV_W-1:0]    div_cnt;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic                tick;
    logic [LED_W-1:0]    led_bits;
    logic [LED_W-1:0]    active_bits;

    assign tick = (div_cnt == DIV_LAST);

    always_ff @(posedge CLK) begin
        if (rs || tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    // Period is MAXL cycles so level MAXL stays solidly on and level 0 solidly off.
    always_ff @(posedge CLK) begin
        if (rs || (pwm_cnt == PWM_LAST)) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
        end
    end

    for (genvar i = 0; i < LED_W; i++) begin : g_ch
        fade_channel #(
            .PWM_BITS (PWM_BITS)
        ) u_ch (
            .CLK     (CLK),
            .rs      (rs),
            .pat_bit (bus.pat_in[i]),
            .tick    (tick),
            .pwm_cnt (pwm_cnt),
            .led_bit (led_bits[i]),
            .active  (active_bits[i])
        );
    end

    assign bus.led_out = led_bits;
    assign bus.busy    = |active_bits;

endmodule

// File: tb/tb_led_fade_pwm.sv
// Directed bench for led_fade_pwm with STEP_DIV = 4 and PWM_BITS = 4.
module tb_led_fade_pwm;
    import led_pkg::*;

    localparam int STEP     = 4;
    localparam int PWM_BITS = 4;
    localparam int MAXL     = 15;

    logic CLK = 1'b0;
    logic rs  = 1'b1;

    led_fade_pwm_if bus ();

    led_fade_pwm #(
        .PWM_BITS (PWM_BITS),
        .STEP_DIV (STEP)
    ) dut (
        .CLK (CLK),
        .rs  (rs),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;
    int last_load [LED_W];
    int model_level [LED_W];
    bit auto_check   = 1'b0;
    int fade_len;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Ticks land on edges t with t % STEP == STEP-1, counting edges from reset release.
    function automatic int ticks_in(input int a, input int b);
        if (b < a) return 0;
        return (b + 1) / STEP - a / STEP;
    endfunction

    task automatic applyReset(input logic [7:0] pat, input int n);
        rs         = 1'b1;
        bus.pat_in = pat;
        for (int k = 0; k < n; k++) begin
            @(posedge CLK);
            #1;
            checkOutput("reset_led", 32'(bus.led_out), 32'h0);
            checkOutput("reset_busy", 32'(bus.busy), 32'h0);
        end
        rs  = 1'b0;
        cyc = 0;
        for (int i = 0; i < LED_W; i++) begin
            last_load[i]   = -1;
            model_level[i] = 0;
        end
    endtask

    // Drive one cycle; the expected brightness follows in closed form from the last load edge.
    task automatic applyStimulus(input logic [7:0] pat);
        int exp_led;
        int exp_busy;
        int lvl;
        int pwm_before;
        bus.pat_in = pat;
        @(posedge CLK);
        #1;
        pwm_before = cyc % MAXL;
        exp_led    = 0;
        exp_busy   = 0;
        for (int i = 0; i < LED_W; i++) begin
            if (pwm_before < model_level[i]) exp_led |= (1 << i);
            if (pat[i]) last_load[i] = cyc;
            if (last_load[i] < 0) begin
                lvl = 0;
            end else if (last_load[i] == cyc) begin
                lvl = MAXL;
            end else begin
                lvl = MAXL - ticks_in(last_load[i] + 1, cyc);
                if (lvl < 0) lvl = 0;
            end
            model_level[i] = lvl;
            if (lvl != 0) exp_busy = 1;
        end
        if (auto_check) begin
            checkOutput($sformatf("led_out@%0d", cyc), 32'(bus.led_out), 32'(exp_led));
            checkOutput($sformatf("busy@%0d", cyc), 32'(bus.busy), 32'(exp_busy));
        end
        cyc++;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.pat_in = '0;
        for (int i = 0; i < LED_W; i++) begin
            last_load[i]   = -1;
            model_level[i] = 0;
        end

        $display("[TB] reset with all requests high");
        applyReset(8'hFF, 2);
        auto_check = 1'b1;
        applyStimulus(8'hFF);
        checkOutput("turn_on_edge0", 32'(bus.led_out), 32'h00);
        checkOutput("busy_edge0", 32'(bus.busy), 32'h1);
        applyStimulus(8'hFF);
        checkOutput("turn_on_edge1", 32'(bus.led_out), 32'hFF);

        $display("[TB] full fade on channel 0");
        applyReset(8'h00, 2);
        repeat (10) applyStimulus(8'h01);
        fade_len = 0;
        do begin
            applyStimulus(8'h00);
            fade_len++;
        end while (bus.busy && fade_len < 100);
        checkOutput("fade_len", 32'(fade_len), 32'd58);
        repeat (16) begin
            applyStimulus(8'h00);
            checkOutput("faded_dark", 32'(bus.led_out), 32'h00);
        end

        $display("[TB] re-trigger mid-fade on channel 3");
        applyReset(8'h00, 2);
        repeat (4) applyStimulus(8'h08);
        repeat (33) applyStimulus(8'h00);
        checkOutput("retrig_busy", 32'(bus.busy), 32'h1);
        applyStimulus(8'h08);
        repeat (6) begin
            applyStimulus(8'h00);
            checkOutput("retrig_lit", 32'(bus.led_out[3]), 32'h1);
        end

        $display("[TB] load colliding with tick on channel 5");
        applyReset(8'h00, 2);
        applyStimulus(8'h20);
        repeat (46) applyStimulus(8'h00);
        applyStimulus(8'h20);
        repeat (5) begin
            applyStimulus(8'h00);
            checkOutput("collide_lit", 32'(bus.led_out), 32'h20);
        end

        $display("[TB] chaser walk");
        applyReset(8'h00, 2);
        for (int i = 0; i < LED_W; i++) begin
            repeat (8) applyStimulus(8'(1 << i));
        end
        repeat (70) applyStimulus(8'h00);
        checkOutput("chaser_idle_led", 32'(bus.led_out), 32'h00);
        checkOutput("chaser_idle_busy", 32'(bus.busy), 32'h0);

        $display("[TB] reset mid-fade");
        applyReset(8'h00, 2);
        repeat (9) applyStimulus(8'h07);
        repeat (12) applyStimulus(8'h03);
        repeat (16) applyStimulus(8'h01);
        repeat (24) applyStimulus(8'h00);
        checkOutput("midfade_busy", 32'(bus.busy), 32'h1);
        applyReset(8'h00, 1);
        applyStimulus(8'h01);
        fade_len = 0;
        do begin
            applyStimulus(8'h00);
            fade_len++;
        end while (bus.busy && fade_len < 100);
        checkOutput("restart_fade_len", 32'(fade_len), 32'd59);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/led_fade_pwm.md
# led_fade_pwm

Downstream stage of the 8-bit LED chaser: consumes the chaser's `led[7:0]` pattern and drives the physical LEDs. A lit bit turns its LED fully on. When the bit drops, the LED fades out in linear PWM brightness steps instead of switching off abruptly. Runs on the chaser's clock and reset and sits between the chaser and the board pins.

## Interface
- `PWM_BITS`, 4: brightness resolution; `MAXL = 2**PWM_BITS - 1` levels (15).
- `STEP_DIV`, 3_125_000: clock cycles per brightness decrement. Must be ≥ 1.
- `CLK` input 1: system clock. All state changes on the rising edge.
- `rs` input 1: reset, synchronous, active-high.
- `pat_in` input 8: pattern from the chaser, sampled every cycle. Bit i = 1 requests LED i on.
- `led_out` output 8: registered PWM drive to the LEDs. 1 = LED lit.
- `busy` output 1: 1 while any channel has a nonzero level (lit or fading).

## Operation
- **Prescaler `div_cnt`**
  - Free-running, counts 0..STEP_DIV-1 and then wraps to 0.
  - `tick` = (`div_cnt` == STEP_DIV-1); it lasts one cycle.
- **PWM counter `pwm_cnt`**
  - Width PWM_BITS, free-running, counts 0..MAXL-1 and then wraps to 0. Period is MAXL cycles.
- **Per-channel level `level[i]`** (PWM_BITS wide, range 0..MAXL). Priority order:
  1. `pat_in[i]` = 1: `level[i]` ← MAXL. Load beats decrement when both happen in the same cycle.
  2. else if `tick` and `level[i]` > 0: `level[i]` ← `level[i]` − 1.
  3. else hold.
- **Arithmetic rules**
  - Level saturates at 0 and never wraps below it.
  - MAXL is a load value only and is never reached by counting up.
- **Output**
  - `led_out[i]` ← (`pwm_cnt` < `level[i]`), registered.
  - Level MAXL gives constant 1. Level 0 gives constant 0. Level L gives exactly L high cycles per MAXL-cycle period.
- **busy**
  - Combinational OR over (`level[i]` != 0).
- **Re-trigger mid-fade**
  - If `pat_in[i]` rises while the channel is fading, it reloads MAXL immediately with no glitch to 0.
- **Channel independence**
  - Each channel is independent. Any subset may load or fade in the same cycle.

## Timing
- **Reset (`rs` = 1 at an edge)**
  - `div_cnt` = 0, `pwm_cnt` = 0, all `level` = 0, `led_out` = 8'h00, `busy` = 0.
  - Reset overrides `pat_in`. Applies mid-fade: all LEDs dark on the next edge.
- **Turn-on latency**
  - `pat_in[i]` high before edge t → `level[i]` = MAXL after t → `led_out[i]` = 1 after edge t+1. Latency is 2 cycles.
- **Fade length**
  - After `pat_in[i]` falls, the first decrement happens on the next `tick`, 1..STEP_DIV cycles later.
  - Level reaches 0 after exactly MAXL ticks.
  - `led_out[i]` is constant 0 from one cycle after `level[i]` reaches 0.
- **First tick after reset**
  - Occurs at cycle STEP_DIV−1 after reset deassertion; edges are counted from 0.

## Structure
- Shared package `led_pkg`:
  - `LED_W` = 8
  - the `MAXL` function/constant of PWM_BITS
  - the level typedef `logic [PWM_BITS-1:0]`
- Sub-module `fade_channel`:
  - Inputs: `CLK`, `rs`, `pat_bit`, `tick`, `pwm_cnt`.
  - Outputs: `led_bit`, `active`.
  - Instantiated 8× in a generate loop.
- Top level holds:
  - the prescaler
  - the PWM counter
  - the `busy` OR

## Test plan
Benches use STEP_DIV = 4 and PWM_BITS = 4 (MAXL = 15).
1. **Reset:** `rs` = 1 for 2 cycles with `pat_in` = 8'hFF → `led_out` = 8'h00 and `busy` = 0 while in reset. After release, `led_out` = 8'hFF from the 2nd edge.
2. **Full fade:** `pat_in` = 8'h01 for 10 cycles, then 8'h00 → `level[0]` decrements 15→0 across exactly 15 ticks (60 cycles ±3). In each 15-cycle PWM window, the `led_out[0]` high count equals the level. `busy` falls when the level reaches 0.
3. **Re-trigger:** drop bit 3, wait for level 7, raise bit 3 → next edge `level[3]` = 15, and `led_out[3]` is constant 1 thereafter with no dark cycle.
4. **Tick collision:** `pat_in[5]` rises in the same cycle as `tick` while `level[5]` = 4 → `level[5]` = 15, not 3.
5. **Chaser pattern:** `pat_in` shifts 8'h01→8'h02→…→8'h80, one step every 8 cycles → trailing channels fade independently with correct per-channel duty. No channel interferes with another.
6. **Reset mid-fade:** `rs` pulse while three channels are at levels 9, 5 and 2 → all `led_out` = 0 and `busy` = 0 on the next edge. The prescaler restarts from 0.
